// File: rtl/sync_edge_filter.sv
// Multi-channel CDC synchroniser with optional per-channel glitch filter and
// registered rise/fall strobes for the frequency-counter front end.
module sync_edge_filter #(
  parameter int                  CHANNELS   = 4,
  parameter int                  STAGES     = 2,
  parameter int                  FILTER_LEN = 4,
  parameter logic [CHANNELS-1:0] RESET_VAL  = {CHANNELS{1'b0}}
) (
  input  logic                clock,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] async_in,
  output logic [CHANNELS-1:0] sync_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic                edge_any
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  if (STAGES < 2) begin : g_bad_stages
    $error("sync_edge_filter: STAGES must be at least 2");
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      // chain_reg[0] is the first capture flop; nothing sits between it and the pin.
      logic [STAGES-1:0] chain_reg;
      logic              s;
      logic              rise_reg;
      logic              fall_reg;

      always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
          chain_reg <= {STAGES{RESET_VAL[gi]}};
        end else begin
          chain_reg <= {chain_reg[STAGES-2:0], async_in[gi]};
        end
      end

      assign s = chain_reg[STAGES-1];

      if (FILTER_LEN == 0) begin : g_bypass
        // Strobe is computed from the level about to shift into the last stage,
        // so it lines up with the cycle in which sync_out first shows it.
        always_ff @(posedge clock or negedge rst_n) begin
          if (!rst_n) begin
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
          end else begin
            rise_reg <= chain_reg[STAGES-2] & ~chain_reg[STAGES-1];
            fall_reg <= ~chain_reg[STAGES-2] & chain_reg[STAGES-1];
          end
        end

        assign sync_out[gi] = s;
      end else begin : g_filter
        localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN - 1);

        logic [CNT_W-1:0] cnt_reg;
        logic [CNT_W-1:0] cnt_next;
        logic             level_reg;
        logic             level_next;
        logic             rise_next;
        logic             fall_next;

        always_comb begin
          cnt_next   = cnt_reg;
          level_next = level_reg;
          rise_next  = 1'b0;
          fall_next  = 1'b0;
          if (s == level_reg) begin
            cnt_next = '0;
          end else if (cnt_reg == CNT_MAX) begin
            level_next = s;
            cnt_next   = '0;
            rise_next  = s;
            fall_next  = ~s;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end

        always_ff @(posedge clock or negedge rst_n) begin
          if (!rst_n) begin
            cnt_reg   <= '0;
            level_reg <= RESET_VAL[gi];
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
          end else begin
            cnt_reg   <= cnt_next;
            level_reg <= level_next;
            rise_reg  <= rise_next;
            fall_reg  <= fall_next;
          end
        end

        assign sync_out[gi] = level_reg;
      end

      assign rise_pulse[gi] = rise_reg;
      assign fall_pulse[gi] = fall_reg;
    end
  endgenerate

  assign edge_any = |(rise_pulse | fall_pulse);

endmodule

// File: tb/tb_sync_edge_filter.sv
// Directed self-checking bench: default instance plus a STAGES=3, unfiltered,
// RESET_VAL=4'hF instance sharing clock and reset.
module tb_sync_edge_filter;

  logic       clock;
  logic       rst_n;
  logic [3:0] async_a;
  logic [3:0] sync_a, rise_a, fall_a;
  logic       edge_a;
  logic [3:0] async_b;
  logic [3:0] sync_b, rise_b, fall_b;
  logic       edge_b;

  int vectors;
  int miscompares;

  sync_edge_filter dut_a (
    .clock      (clock),
    .rst_n      (rst_n),
    .async_in   (async_a),
    .sync_out   (sync_a),
    .rise_pulse (rise_a),
    .fall_pulse (fall_a),
    .edge_any   (edge_a)
  );

  sync_edge_filter #(
    .CHANNELS   (4),
    .STAGES     (3),
    .FILTER_LEN (0),
    .RESET_VAL  (4'hF)
  ) dut_b (
    .clock      (clock),
    .rst_n      (rst_n),
    .async_in   (async_b),
    .sync_out   (sync_b),
    .rise_pulse (rise_b),
    .fall_pulse (fall_b),
    .edge_any   (edge_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
    $display("vec %0d %s observed %0h expected %0h", vectors, tag, observed, expected);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    async_a     = 4'hF;
    async_b     = 4'hF;

    // 1: held in reset with inputs high, then release with inputs low
    #2;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("rst_sync_a", 32'(sync_a), 32'h0);
      check("rst_strobes_a", {23'd0, rise_a, fall_a, edge_a}, 32'h0);
      check("rst_sync_b", 32'(sync_b), 32'hF);
    end
    async_a = 4'h0;
    rst_n   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("post_rst_strobes_a", {23'd0, rise_a, fall_a, edge_a}, 32'h0);
      check("post_rst_strobes_b", {23'd0, rise_b, fall_b, edge_b}, 32'h0);
    end
    check("post_rst_sync_a", 32'(sync_a), 32'h0);
    check("post_rst_sync_b", 32'(sync_b), 32'hF);

    // 2: ch0 rises, accepted at posedge k+5
    async_a[0] = 1'b1;
    step(5);
    check("ch0_k4_sync", 32'(sync_a), 32'h0);
    check("ch0_k4_rise", 32'(rise_a), 32'h0);
    step(1);
    check("ch0_k5_sync", 32'(sync_a), 32'h1);
    check("ch0_k5_rise", 32'(rise_a), 32'h1);
    check("ch0_k5_fall", 32'(fall_a), 32'h0);
    check("ch0_k5_edge", 32'(edge_a), 32'h1);
    step(1);
    check("ch0_k6_rise", 32'(rise_a), 32'h0);
    check("ch0_k6_edge", 32'(edge_a), 32'h0);
    check("ch0_k6_sync", 32'(sync_a), 32'h1);

    // 3: ch1 glitch of 3 periods rejected, 4 periods accepted
    async_a[1] = 1'b1;
    step(3);
    async_a[1] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      check("ch1_short_sync", 32'(sync_a), 32'h1);
      check("ch1_short_strobes", {23'd0, rise_a, fall_a, edge_a}, 32'h0);
    end
    async_a[1] = 1'b1;
    step(4);
    async_a[1] = 1'b0;
    step(1);
    check("ch1_k4_sync", 32'(sync_a), 32'h1);
    step(1);
    check("ch1_k5_sync", 32'(sync_a), 32'h3);
    check("ch1_k5_rise", 32'(rise_a), 32'h2);
    step(1);
    check("ch1_k6_rise", 32'(rise_a), 32'h0);
    step(2);
    check("ch1_k8_sync", 32'(sync_a), 32'h3);
    check("ch1_k8_fall", 32'(fall_a), 32'h0);
    step(1);
    check("ch1_k9_sync", 32'(sync_a), 32'h1);
    check("ch1_k9_fall", 32'(fall_a), 32'h2);
    check("ch1_k9_edge", 32'(edge_a), 32'h1);
    step(1);
    check("ch1_k10_fall", 32'(fall_a), 32'h0);

    // 4: ch3 settled high, then ch2 rises and ch3 falls together
    async_a[3] = 1'b1;
    step(8);
    check("ch3_settled", 32'(sync_a), 32'h9);
    async_a[2] = 1'b1;
    async_a[3] = 1'b0;
    step(5);
    check("dual_k4_strobes", {23'd0, rise_a, fall_a, edge_a}, 32'h0);
    step(1);
    check("dual_k5_rise", 32'(rise_a), 32'h4);
    check("dual_k5_fall", 32'(fall_a), 32'h8);
    check("dual_k5_edge", 32'(edge_a), 32'h1);
    check("dual_k5_sync", 32'(sync_a), 32'h5);
    step(1);
    check("dual_k6_strobes", {23'd0, rise_a, fall_a, edge_a}, 32'h0);

    // 5: reset pulse mid-filter restarts the full latency
    async_a = 4'h0;
    step(8);
    check("settle_low", 32'(sync_a), 32'h0);
    async_a[0] = 1'b1;
    step(4);
    check("mid_filter_sync", 32'(sync_a), 32'h0);
    rst_n = 1'b0;
    #1;
    check("async_rst_sync", 32'(sync_a), 32'h0);
    check("async_rst_strobes", {23'd0, rise_a, fall_a, edge_a}, 32'h0);
    #3;
    rst_n = 1'b1;
    step(1);
    step(4);
    check("rst_restart_m4_sync", 32'(sync_a), 32'h0);
    check("rst_restart_m4_rise", 32'(rise_a), 32'h0);
    step(1);
    check("rst_restart_m5_sync", 32'(sync_a), 32'h1);
    check("rst_restart_m5_rise", 32'(rise_a), 32'h1);

    // 6: unfiltered 3-stage instance, ch2 falls
    check("b_idle_sync", 32'(sync_b), 32'hF);
    async_b[2] = 1'b0;
    step(2);
    check("b_k1_sync", 32'(sync_b), 32'hF);
    check("b_k1_fall", 32'(fall_b), 32'h0);
    step(1);
    check("b_k2_sync", 32'(sync_b), 32'hB);
    check("b_k2_fall", 32'(fall_b), 32'h4);
    check("b_k2_rise", 32'(rise_b), 32'h0);
    check("b_k2_edge", 32'(edge_b), 32'h1);
    step(1);
    check("b_k3_strobes", {23'd0, rise_b, fall_b, edge_b}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
